// File: rtl/cmp_arbiter.sv
// cmp_arbiter: shares one asynchronous equalOrNot comparator among N clocked requesters.
// Round-robin picks a requester, its operands are registered onto cmp_x_o/cmp_y_o, and the
// comparator's four-phase req/fin handshake is sequenced with its outputs double-flop
// synchronized. The verdict returns as a one-cycle done_o pulse; a watchdog aborts stalls.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_i[N]                      level requests, held until the matching done_o bit pulses
//   x_i, y_i[N*Width]             packed operands, slice i = [i*Width +: Width]
//   done_o[N]                     one-hot completion pulse
//   equal_o, notEqual_o, err_o    verdict / abort flag, valid with done_o
//   busy_o                        high whenever the controller is not idle
//   grant_o                       current or last granted requester
//   cmp_req_o, cmp_x_o, cmp_y_o   registered request and operands to the comparator
//   cmp_fin_i, cmp_equal_i,
//   cmp_notEqual_i                asynchronous comparator outputs
module cmp_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned Width   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req_i,
    input  logic [N*Width-1:0]     x_i,
    input  logic [N*Width-1:0]     y_i,
    output logic [N-1:0]           done_o,
    output logic                   equal_o,
    output logic                   notEqual_o,
    output logic                   err_o,
    output logic                   busy_o,
    output logic [$clog2(N)-1:0]   grant_o,
    output logic                   cmp_req_o,
    output logic [Width-1:0]       cmp_x_o,
    output logic [Width-1:0]       cmp_y_o,
    input  logic                   cmp_fin_i,
    input  logic                   cmp_equal_i,
    input  logic                   cmp_notEqual_i
);

    localparam int unsigned GW = $clog2(N);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StSetup, StWaitFin, StWaitClr, StDone} state_e;

    state_e             state_q, state_d;
    logic [GW-1:0]      ptr_q, ptr_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [Width-1:0]   cmp_x_q, cmp_x_d;
    logic [Width-1:0]   cmp_y_q, cmp_y_d;
    logic               cmp_req_q, cmp_req_d;
    logic [CW-1:0]      wdog_q, wdog_d;
    logic               cap_eq_q, cap_eq_d;
    logic               cap_ne_q, cap_ne_d;
    logic               err_flag_q, err_flag_d;
    logic [N-1:0]       done_q, done_d;
    logic               equal_q, equal_d;
    logic               not_equal_q, not_equal_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    // {fin, equal, notEqual}: first stage, then the usable *_s stage
    logic [2:0]         sync1_q, sync1_d;
    logic [2:0]         sync_s_q, sync_s_d;

    logic               cmp_fin_s, cmp_equal_s, cmp_notEqual_s;
    logic [GW-1:0]      win, idx;
    logic               win_vld;
    logic               go_done, abort;

    logic [Width-1:0]   x_arr [N];
    logic [Width-1:0]   y_arr [N];

    for (genvar g = 0; g < N; g++) begin : g_slice
        assign x_arr[g] = x_i[g*Width +: Width];
        assign y_arr[g] = y_i[g*Width +: Width];
    end

    assign cmp_fin_s      = sync_s_q[2];
    assign cmp_equal_s    = sync_s_q[1];
    assign cmp_notEqual_s = sync_s_q[0];

    // Round-robin search starting at the pointer, wrapping N-1 -> 0
    always_comb begin
        win     = ptr_q;
        idx     = ptr_q;
        win_vld = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = GW'((32'(ptr_q) + k) % N);
            if (!win_vld && req_i[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        cmp_x_d     = cmp_x_q;
        cmp_y_d     = cmp_y_q;
        cmp_req_d   = cmp_req_q;
        wdog_d      = wdog_q;
        cap_eq_d    = cap_eq_q;
        cap_ne_d    = cap_ne_q;
        err_flag_d  = err_flag_q;
        done_d      = '0;
        equal_d     = 1'b0;
        not_equal_d = 1'b0;
        err_d       = 1'b0;
        go_done     = 1'b0;
        abort       = 1'b0;
        sync1_d     = {cmp_fin_i, cmp_equal_i, cmp_notEqual_i};
        sync_s_d    = sync1_q;

        unique case (state_q)
            StIdle: begin
                // A fin still high from an aborted transaction blocks new grants
                if (win_vld && !cmp_fin_s) begin
                    grant_d    = win;
                    cmp_x_d    = x_arr[win];
                    cmp_y_d    = y_arr[win];
                    err_flag_d = 1'b0;
                    state_d    = StSetup;
                end
            end
            StSetup: begin
                // Operands were registered last cycle; raise req only now
                cmp_req_d = 1'b1;
                wdog_d    = '0;
                state_d   = StWaitFin;
            end
            StWaitFin: begin
                if (cmp_fin_s) begin
                    cap_eq_d   = cmp_equal_s;
                    cap_ne_d   = cmp_notEqual_s;
                    err_flag_d = (cmp_equal_s == cmp_notEqual_s);
                    cmp_req_d  = 1'b0;
                    wdog_d     = '0;
                    state_d    = StWaitClr;
                end else if (wdog_q == CW'(TIMEOUT)) begin
                    abort = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StWaitClr: begin
                if (!cmp_fin_s) begin
                    go_done = 1'b1;
                end else if (wdog_q == CW'(TIMEOUT)) begin
                    abort = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StDone: begin
                ptr_d   = (grant_q == GW'(N - 1)) ? '0 : grant_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (abort) begin
            cmp_req_d  = 1'b0;
            err_flag_d = 1'b1;
            go_done    = 1'b1;
        end

        // Outputs are registered, so they are loaded on the edge entering DONE
        if (go_done) begin
            state_d          = StDone;
            done_d[grant_q]  = 1'b1;
            err_d            = err_flag_d;
            equal_d          = !err_flag_d && cap_eq_d;
            not_equal_d      = !err_flag_d && cap_ne_d;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            grant_q     <= '0;
            cmp_x_q     <= '0;
            cmp_y_q     <= '0;
            cmp_req_q   <= 1'b0;
            wdog_q      <= '0;
            cap_eq_q    <= 1'b0;
            cap_ne_q    <= 1'b0;
            err_flag_q  <= 1'b0;
            done_q      <= '0;
            equal_q     <= 1'b0;
            not_equal_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            sync1_q     <= '0;
            sync_s_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            cmp_x_q     <= cmp_x_d;
            cmp_y_q     <= cmp_y_d;
            cmp_req_q   <= cmp_req_d;
            wdog_q      <= wdog_d;
            cap_eq_q    <= cap_eq_d;
            cap_ne_q    <= cap_ne_d;
            err_flag_q  <= err_flag_d;
            done_q      <= done_d;
            equal_q     <= equal_d;
            not_equal_q <= not_equal_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            sync1_q     <= sync1_d;
            sync_s_q    <= sync_s_d;
        end
    end

    assign done_o     = done_q;
    assign equal_o    = equal_q;
    assign notEqual_o = not_equal_q;
    assign err_o      = err_q;
    assign busy_o     = busy_q;
    assign grant_o    = grant_q;
    assign cmp_req_o  = cmp_req_q;
    assign cmp_x_o    = cmp_x_q;
    assign cmp_y_o    = cmp_y_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: directed scenarios plus randomized requests checked
// against a round-robin reference model. The comparator is modelled as zero-delay, with
// controls to stall fin, force fin high, or return an invalid verdict.
module tb_cmp_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   x = '0;
    logic [N*W-1:0]   y = '0;
    logic [N-1:0]     done_o;
    logic             equal_o, notEqual_o, err_o, busy_o;
    logic [1:0]       grant_o;
    logic             cmp_req_o;
    logic [W-1:0]     cmp_x_o, cmp_y_o;
    logic             cmp_fin, cmp_eq, cmp_ne;

    logic             force_en  = 1'b0;
    logic             force_val = 1'b0;
    logic             bad       = 1'b0;

    int               errors = 0;
    int               checks = 0;
    int               rr_ptr = 0;

    assign cmp_fin = force_en ? force_val : cmp_req_o;
    assign cmp_eq  = bad | (cmp_req_o & (cmp_x_o == cmp_y_o));
    assign cmp_ne  = bad | (cmp_req_o & (cmp_x_o != cmp_y_o));

    cmp_arbiter #(.N(N), .Width(W), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req),
        .x_i            (x),
        .y_i            (y),
        .done_o         (done_o),
        .equal_o        (equal_o),
        .notEqual_o     (notEqual_o),
        .err_o          (err_o),
        .busy_o         (busy_o),
        .grant_o        (grant_o),
        .cmp_req_o      (cmp_req_o),
        .cmp_x_o        (cmp_x_o),
        .cmp_y_o        (cmp_y_o),
        .cmp_fin_i      (cmp_fin),
        .cmp_equal_i    (cmp_eq),
        .cmp_notEqual_i (cmp_ne)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic wait_done(input int max_n, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < max_n) begin
            @(negedge clk);
            n++;
            if (done_o != '0) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks += 9;
        if (done_o !== '0)    begin errors++; $display("FAIL rst_done: got %b want 0", done_o); end
        if (equal_o !== 1'b0) begin errors++; $display("FAIL rst_equal: got %b want 0", equal_o); end
        if (notEqual_o !== 1'b0) begin errors++; $display("FAIL rst_neq: got %b want 0", notEqual_o); end
        if (err_o !== 1'b0)   begin errors++; $display("FAIL rst_err: got %b want 0", err_o); end
        if (busy_o !== 1'b0)  begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        if (grant_o !== 2'd0) begin errors++; $display("FAIL rst_grant: got %0d want 0", grant_o); end
        if (cmp_req_o !== 1'b0) begin errors++; $display("FAIL rst_cmp_req: got %b want 0", cmp_req_o); end
        if (cmp_x_o !== '0)   begin errors++; $display("FAIL rst_cmp_x: got %h want 0", cmp_x_o); end
        if (cmp_y_o !== '0)   begin errors++; $display("FAIL rst_cmp_y: got %h want 0", cmp_y_o); end
        rst    = 1'b0;
        rr_ptr = 0;
    endtask

    task automatic test_single_equal();
        x[0*W +: W] = 32'hDEADBEEF;
        y[0*W +: W] = 32'hDEADBEEF;
        req = 4'b0001;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (n == 1) begin
                checks += 3;
                if (busy_o !== 1'b1) begin errors++; $display("FAIL eq_busy: got %b want 1", busy_o); end
                if (cmp_x_o !== 32'hDEADBEEF) begin errors++; $display("FAIL eq_cmp_x: got %h want deadbeef", cmp_x_o); end
                if (cmp_y_o !== 32'hDEADBEEF) begin errors++; $display("FAIL eq_cmp_y: got %h want deadbeef", cmp_y_o); end
            end
            if (n == 2) begin
                checks++;
                if (cmp_req_o !== 1'b1) begin errors++; $display("FAIL eq_req_rise: got %b want 1", cmp_req_o); end
            end
            if (n == 7) begin
                checks++;
                if (done_o !== 4'b0000) begin errors++; $display("FAIL eq_early_done: got %b want 0000", done_o); end
            end
            if (n == 8) begin
                checks += 4;
                if (done_o !== 4'b0001) begin errors++; $display("FAIL eq_done: got %b want 0001", done_o); end
                if (equal_o !== 1'b1)   begin errors++; $display("FAIL eq_equal: got %b want 1", equal_o); end
                if (notEqual_o !== 1'b0) begin errors++; $display("FAIL eq_neq: got %b want 0", notEqual_o); end
                if (err_o !== 1'b0)     begin errors++; $display("FAIL eq_err: got %b want 0", err_o); end
                req = '0;
            end
            if (n == 9) begin
                checks += 2;
                if (done_o !== 4'b0000) begin errors++; $display("FAIL eq_done_width: got %b want 0000", done_o); end
                if (equal_o !== 1'b0)   begin errors++; $display("FAIL eq_equal_width: got %b want 0", equal_o); end
            end
        end
        rr_ptr = 1;
    endtask

    task automatic test_single_neq();
        int n;
        bit seen;
        x[2*W +: W] = 32'd5;
        y[2*W +: W] = 32'd6;
        req = 4'b0100;
        wait_done(20, n, seen);
        req = '0;
        checks += 6;
        if (!seen || n != 8) begin errors++; $display("FAIL neq_latency: got %0d want 8", n); end
        if (done_o !== 4'b0100) begin errors++; $display("FAIL neq_done: got %b want 0100", done_o); end
        if (notEqual_o !== 1'b1) begin errors++; $display("FAIL neq_neq: got %b want 1", notEqual_o); end
        if (equal_o !== 1'b0)   begin errors++; $display("FAIL neq_equal: got %b want 0", equal_o); end
        if (err_o !== 1'b0)     begin errors++; $display("FAIL neq_err: got %b want 0", err_o); end
        if (grant_o !== 2'd2)   begin errors++; $display("FAIL neq_grant: got %0d want 2", grant_o); end
        rr_ptr = 3;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int n;
        bit seen;
        logic [N-1:0] want;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] v;
            v = $urandom;
            x[i*W +: W] = v;
            y[i*W +: W] = v;
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            want = 4'b0001 << (k % N);
            wait_done(20, n, seen);
            checks += 3;
            if (!seen) begin errors++; $display("FAIL rr_wait_%0d: no done within 20 cycles", k); end
            if (done_o !== want) begin errors++; $display("FAIL rr_done_%0d: got %b want %b", k, done_o, want); end
            if (equal_o !== 1'b1) begin errors++; $display("FAIL rr_equal_%0d: got %b want 1", k, equal_o); end
            @(negedge clk);
            checks++;
            if (done_o !== '0) begin errors++; $display("FAIL rr_width_%0d: got %b want 0000", k, done_o); end
        end
        req    = '0;
        rr_ptr = 1;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        bit seen;
        force_en  = 1'b1;
        force_val = 1'b0;
        x[0*W +: W] = 32'h1;
        y[0*W +: W] = 32'h1;
        req = 4'b0001;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if (c == 18) begin
                checks += 2;
                if (cmp_req_o !== 1'b1) begin errors++; $display("FAIL to_req_held: got %b want 1", cmp_req_o); end
                if (done_o !== '0) begin errors++; $display("FAIL to_early_done: got %b want 0000", done_o); end
            end
            if (c == 19) begin
                checks += 5;
                if (cmp_req_o !== 1'b0) begin errors++; $display("FAIL to_req_fall: got %b want 0", cmp_req_o); end
                if (done_o !== 4'b0001) begin errors++; $display("FAIL to_done: got %b want 0001", done_o); end
                if (err_o !== 1'b1)     begin errors++; $display("FAIL to_err: got %b want 1", err_o); end
                if (equal_o !== 1'b0)   begin errors++; $display("FAIL to_equal: got %b want 0", equal_o); end
                if (notEqual_o !== 1'b0) begin errors++; $display("FAIL to_neq: got %b want 0", notEqual_o); end
            end
        end
        req       = '0;
        force_val = 1'b1;
        repeat (3) @(negedge clk);
        x[1*W +: W] = 32'h7;
        y[1*W +: W] = 32'h7;
        req = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (busy_o !== 1'b0 || done_o !== '0) begin
                errors++;
                $display("FAIL to_fin_guard_%0d: got busy=%b done=%b want busy=0 done=0000", c, busy_o, done_o);
            end
        end
        force_en = 1'b0;
        wait_done(20, n, seen);
        req = '0;
        checks += 4;
        if (!seen) begin errors++; $display("FAIL to_resume_wait: no done within 20 cycles"); end
        if (done_o !== 4'b0010) begin errors++; $display("FAIL to_resume_done: got %b want 0010", done_o); end
        if (equal_o !== 1'b1)   begin errors++; $display("FAIL to_resume_equal: got %b want 1", equal_o); end
        if (grant_o !== 2'd1)   begin errors++; $display("FAIL to_resume_grant: got %0d want 1", grant_o); end
        rr_ptr = 2;
        @(negedge clk);
    endtask

    task automatic test_invalid();
        int n;
        bit seen;
        bad = 1'b1;
        req = 4'b0100;
        wait_done(20, n, seen);
        req = '0;
        checks += 5;
        if (!seen) begin errors++; $display("FAIL inv_wait: no done within 20 cycles"); end
        if (done_o !== 4'b0100) begin errors++; $display("FAIL inv_done: got %b want 0100", done_o); end
        if (err_o !== 1'b1)     begin errors++; $display("FAIL inv_err: got %b want 1", err_o); end
        if (equal_o !== 1'b0)   begin errors++; $display("FAIL inv_equal: got %b want 0", equal_o); end
        if (notEqual_o !== 1'b0) begin errors++; $display("FAIL inv_neq: got %b want 0", notEqual_o); end
        bad    = 1'b0;
        rr_ptr = 3;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen;
        force_en  = 1'b1;
        force_val = 1'b0;
        req = 4'b1000;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks += 4;
        if (cmp_req_o !== 1'b0) begin errors++; $display("FAIL rm_cmp_req: got %b want 0", cmp_req_o); end
        if (busy_o !== 1'b0)    begin errors++; $display("FAIL rm_busy: got %b want 0", busy_o); end
        if (done_o !== '0)      begin errors++; $display("FAIL rm_done: got %b want 0000", done_o); end
        if (grant_o !== 2'd0)   begin errors++; $display("FAIL rm_grant: got %0d want 0", grant_o); end
        rst      = 1'b0;
        force_en = 1'b0;
        // Pointer back at 0 selects requester 2; a stale pointer of 3 would pick 3
        req = 4'b1100;
        wait_done(20, n, seen);
        req = '0;
        checks += 2;
        if (!seen || done_o !== 4'b0100) begin errors++; $display("FAIL rm_ptr_done: got %b want 0100", done_o); end
        if (grant_o !== 2'd2) begin errors++; $display("FAIL rm_ptr_grant: got %0d want 2", grant_o); end
        rr_ptr = 3;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit [N-1:0]   pending;
        logic [W-1:0] px [N];
        logic [W-1:0] py [N];
        int           w, n;
        bit           seen;
        pending = '0;
        for (int i = 0; i < N; i++) begin
            px[i] = $urandom;
            py[i] = ($urandom_range(0, 1) == 1) ? px[i] : $urandom;
            pending[i] = ($urandom_range(0, 1) == 1);
        end
        if (pending == '0) pending[$urandom_range(0, N - 1)] = 1'b1;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                x[i*W +: W] = px[i];
                y[i*W +: W] = py[i];
            end
            req = pending;
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && pending[(rr_ptr + k) % N]) w = (rr_ptr + k) % N;
            end
            wait_done(30, n, seen);
            checks += 5;
            if (!seen) begin errors++; $display("FAIL rnd_wait_%0d: no done within 30 cycles", it); end
            if (done_o !== (4'b0001 << w)) begin
                errors++; $display("FAIL rnd_done_%0d: got %b want %b", it, done_o, 4'b0001 << w);
            end
            if (grant_o !== 2'(w)) begin errors++; $display("FAIL rnd_grant_%0d: got %0d want %0d", it, grant_o, w); end
            if (equal_o !== (px[w] == py[w]) || notEqual_o !== (px[w] != py[w])) begin
                errors++;
                $display("FAIL rnd_verdict_%0d: got eq=%b ne=%b want eq=%b", it, equal_o, notEqual_o, px[w] == py[w]);
            end
            if (err_o !== 1'b0) begin errors++; $display("FAIL rnd_err_%0d: got %b want 0", it, err_o); end
            pending[w] = 1'b0;
            rr_ptr = (w + 1) % N;
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(0, 1) == 1) begin
                    pending[i] = 1'b1;
                    px[i] = $urandom;
                    py[i] = ($urandom_range(0, 1) == 1) ? px[i] : $urandom;
                end
            end
            if (pending == '0) begin
                w = $urandom_range(0, N - 1);
                pending[w] = 1'b1;
                px[w] = $urandom;
                py[w] = px[w];
            end
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_equal();
        test_single_neq();
        test_round_robin();
        test_timeout();
        test_invalid();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
